// File: rtl/key_freq_ctrl.sv
// ---------------------------------------------------------------------------
// key_freq_ctrl
//
// Push-button frequency-word controller for the DDS phase-accumulator step.
// Three raw, active-low keys (up, down, step-select) are synchronised and
// debounced. Up/down presses step the frequency word by the selected decade
// step, with hold-to-repeat. The result is clamped to [FRE_MIN, FRE_MAX].
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   key_up_n   in   raw up key, 0 = pressed
//   key_dn_n   in   raw down key, 0 = pressed
//   key_step_n in   raw step-select key, 0 = pressed
//   fre_k      out  current frequency word (FW bits, registered)
//   step_idx   out  current step decade index (step = STEP_BASE*10**idx)
//   fre_upd    out  one-cycle pulse in the cycle fre_k takes a new value
//   at_min     out  fre_k == FRE_MIN (registered)
//   at_max     out  fre_k == FRE_MAX (registered)
// ---------------------------------------------------------------------------
module key_freq_ctrl #(
  parameter int unsigned    FW            = 32,
  parameter logic [FW-1:0]  FRE_INIT      = FW'(1000),
  parameter logic [FW-1:0]  FRE_MIN       = FW'(1),
  parameter logic [FW-1:0]  FRE_MAX       = FW'(64'h8000_0000),
  parameter int unsigned    STEP_BASE     = 1,
  parameter int unsigned    DEB_CYCLES    = 500000,
  parameter int unsigned    REPEAT_DELAY  = 25000000,
  parameter int unsigned    REPEAT_PERIOD = 5000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_up_n,
  input  logic          key_dn_n,
  input  logic          key_step_n,
  output logic [FW-1:0] fre_k,
  output logic [1:0]    step_idx,
  output logic          fre_upd,
  output logic          at_min,
  output logic          at_max
);

  // -------------------------------------------------------------------------
  // Counter widths and terminal counts
  // -------------------------------------------------------------------------
  localparam int unsigned DW       = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RPT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
  localparam int unsigned RW       = $clog2(RPT_SPAN + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  localparam logic AT_MIN_INIT = (FRE_INIT == FRE_MIN);
  localparam logic AT_MAX_INIT = (FRE_INIT == FRE_MAX);

  typedef enum logic [1:0] {
    RPT_IDLE = 2'd0,
    RPT_WAIT = 2'd1,
    RPT_RUN  = 2'd2
  } rpt_state_t;

  // -------------------------------------------------------------------------
  // Step table: STEP_BASE * 10**i, i = 0..3
  // -------------------------------------------------------------------------
  logic [FW-1:0] step_tab [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_step
    localparam logic [63:0] STEP_L = 64'(STEP_BASE) * (64'd10 ** gi);
    assign step_tab[gi] = STEP_L[FW-1:0];
  end

  // -------------------------------------------------------------------------
  // Key front end: 2-FF synchroniser + debouncer + press-edge detect.
  // Bit 0 = up, bit 1 = down, bit 2 = step-select.
  // -------------------------------------------------------------------------
  logic [2:0] key_raw;
  logic [2:0] press;       // debounced 1->0 transition seen on the previous edge
  logic [1:0] deb_state;   // debounced level of up/down (1 = released)

  assign key_raw = {key_step_n, key_dn_n, key_up_n};

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    logic          sync1_reg;
    logic          sync2_reg;
    logic          deb_reg;
    logic          deb_d_reg;
    logic [DW-1:0] cnt_reg;

    // Synchronisers and debounced state come out of reset released, so a key
    // still held at reset exit must be re-qualified for the full debounce time.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_reg <= 1'b1;
        sync2_reg <= 1'b1;
        deb_reg   <= 1'b1;
        deb_d_reg <= 1'b1;
        cnt_reg   <= '0;
      end else begin
        sync1_reg <= key_raw[gi];
        sync2_reg <= sync1_reg;
        deb_d_reg <= deb_reg;
        // Count consecutive disagreeing samples; any agreement restarts.
        if (sync2_reg == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DEB_LAST) begin
          deb_reg <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + DW'(1);
        end
      end
    end

    assign press[gi] = deb_d_reg & ~deb_reg;

    if (gi < 2) begin : g_lvl
      assign deb_state[gi] = deb_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Repeat FSMs (bit 0 = up, bit 1 = down). The request is registered, so it
  // is presented to the arithmetic stage the cycle after the FSM decides it.
  // -------------------------------------------------------------------------
  logic [1:0] step_req;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rpt
    rpt_state_t    state_reg;
    rpt_state_t    state_next;
    logic [RW-1:0] cnt_reg;
    logic [RW-1:0] cnt_next;
    logic          req_reg;
    logic          req_next;
    logic          held;

    assign held = ~deb_state[gi];

    // State register
    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg <= RPT_IDLE;
        cnt_reg   <= '0;
        req_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        req_reg   <= req_next;
      end
    end

    // Next-state logic
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
        RPT_IDLE: begin
          if (press[gi]) begin
            state_next = RPT_WAIT;
            cnt_next   = '0;
          end
        end
        RPT_WAIT: begin
          if (!held) begin
            state_next = RPT_IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == DLY_LAST) begin
            state_next = RPT_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + RW'(1);
          end
        end
        RPT_RUN: begin
          if (!held) begin
            state_next = RPT_IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == PER_LAST) begin
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + RW'(1);
          end
        end
        default: begin
          state_next = RPT_IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    // Output logic: a release always wins over a pending repeat.
    always_comb begin
      req_next = 1'b0;
      case (state_reg)
        RPT_IDLE: req_next = press[gi];
        RPT_WAIT: req_next = held && (cnt_reg == DLY_LAST);
        RPT_RUN:  req_next = held && (cnt_reg == PER_LAST);
        default:  req_next = 1'b0;
      endcase
    end

    assign step_req[gi] = req_reg;
  end

  // -------------------------------------------------------------------------
  // Step selection and frequency arithmetic
  // -------------------------------------------------------------------------
  logic [FW-1:0] fre_reg;
  logic          fre_upd_reg;
  logic          at_min_reg;
  logic          at_max_reg;
  logic [1:0]    step_idx_reg;
  logic [FW-1:0] step_val_reg;   // step captured alongside the request

  logic [FW:0]   fre_x;
  logic [FW:0]   step_x;
  logic [FW:0]   sum_x;
  logic [FW:0]   floor_x;
  logic [FW:0]   up_x;
  logic [FW:0]   dn_x;
  logic [FW:0]   nxt_x;
  logic          apply;

  // One extra bit keeps the up-sum and the down-threshold from wrapping.
  always_comb begin
    fre_x   = {1'b0, fre_reg};
    step_x  = {1'b0, step_val_reg};
    sum_x   = fre_x + step_x;
    floor_x = {1'b0, FRE_MIN} + step_x;
    up_x    = (sum_x > {1'b0, FRE_MAX}) ? {1'b0, FRE_MAX} : sum_x;
    dn_x    = (fre_x < floor_x) ? {1'b0, FRE_MIN} : (fre_x - step_x);
    nxt_x   = step_req[0] ? up_x : dn_x;
    // Coincident up and down requests cancel each other.
    apply   = step_req[0] ^ step_req[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fre_reg      <= FRE_INIT;
      fre_upd_reg  <= 1'b0;
      at_min_reg   <= AT_MIN_INIT;
      at_max_reg   <= AT_MAX_INIT;
      step_idx_reg <= 2'd0;
      step_val_reg <= step_tab[0];
    end else begin
      // Sampled with the pre-increment index, so a step change only affects
      // requests issued on later cycles.
      step_val_reg <= step_tab[step_idx_reg];
      if (press[2]) begin
        step_idx_reg <= step_idx_reg + 2'd1;
      end
      fre_upd_reg <= 1'b0;
      if (apply) begin
        fre_reg     <= nxt_x[FW-1:0];
        fre_upd_reg <= (nxt_x != fre_x);
        at_min_reg  <= (nxt_x == {1'b0, FRE_MIN});
        at_max_reg  <= (nxt_x == {1'b0, FRE_MAX});
      end
    end
  end

  assign fre_k    = fre_reg;
  assign fre_upd  = fre_upd_reg;
  assign at_min   = at_min_reg;
  assign at_max   = at_max_reg;
  assign step_idx = step_idx_reg;

endmodule

// File: tb/tb_key_freq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_freq_ctrl
//
// Directed scenarios followed by randomized key activity. Every cycle the
// DUT outputs are compared against a behavioural model that works from key
// levels, hold ages and plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_key_freq_ctrl;

  localparam int FINIT = 1000;
  localparam int FMIN  = 10;
  localparam int FMAX  = 1100;
  localparam int DEB   = 4;
  localparam int RD    = 20;
  localparam int RP    = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_up_n;
  logic        key_dn_n;
  logic        key_step_n;
  logic [31:0] fre_k;
  logic [1:0]  step_idx;
  logic        fre_upd;
  logic        at_min;
  logic        at_max;

  always #5 clk = ~clk;

  key_freq_ctrl #(
    .FW            (32),
    .FRE_INIT      (32'd1000),
    .FRE_MIN       (32'd10),
    .FRE_MAX       (32'd1100),
    .STEP_BASE     (1),
    .DEB_CYCLES    (4),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_up_n   (key_up_n),
    .key_dn_n   (key_dn_n),
    .key_step_n (key_step_n),
    .fre_k      (fre_k),
    .step_idx   (step_idx),
    .fre_upd    (fre_upd),
    .at_min     (at_min),
    .at_max     (at_max)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  int   steps [4] = '{1, 10, 100, 1000};
  bit   m_valid = 1'b0;
  int   m_fre;
  bit   m_upd;
  int   m_step_idx;
  bit   m_up_req, m_dn_req;
  int   m_step_val;
  bit   m_p1 [3];       // raw level one edge ago
  bit   m_p2 [3];       // raw level two edges ago (what the debouncer sees)
  bit   m_deb [3];
  int   m_run [3];
  bit   m_press [3];
  bit   m_active [2];
  int   m_age [2];      // edges since the press request while held

  task automatic model_edge(input bit r, input bit [2:0] raw);
    bit new_req [2];
    int nxt;
    if (r) begin
      m_fre = FINIT; m_upd = 0; m_step_idx = 0;
      m_up_req = 0; m_dn_req = 0; m_step_val = steps[0];
      for (int k = 0; k < 3; k++) begin
        m_p1[k] = 1; m_p2[k] = 1; m_deb[k] = 1; m_run[k] = 0; m_press[k] = 0;
      end
      for (int k = 0; k < 2; k++) begin
        m_active[k] = 0; m_age[k] = 0;
      end
      return;
    end
    // apply the request issued on the previous edge
    m_upd = 0;
    if (m_up_req != m_dn_req) begin
      if (m_up_req) nxt = (m_fre + m_step_val > FMAX) ? FMAX : m_fre + m_step_val;
      else          nxt = (m_fre - m_step_val < FMIN) ? FMIN : m_fre - m_step_val;
      m_upd = (nxt != m_fre);
      m_fre = nxt;
    end
    // hold-to-repeat by age since the press
    for (int k = 0; k < 2; k++) begin
      new_req[k] = 0;
      if (m_active[k]) begin
        if (m_deb[k]) m_active[k] = 0;
        else begin
          m_age[k]++;
          if (m_age[k] == RD || (m_age[k] > RD && (m_age[k] - RD) % RP == 0))
            new_req[k] = 1;
        end
      end else if (m_press[k]) begin
        m_active[k] = 1; m_age[k] = 0; new_req[k] = 1;
      end
    end
    m_step_val = steps[m_step_idx];
    m_up_req = new_req[0];
    m_dn_req = new_req[1];
    if (m_press[2]) m_step_idx = (m_step_idx + 1) % 4;
    // debounce on the twice-delayed raw level
    for (int k = 0; k < 3; k++) begin
      m_press[k] = 0;
      if (m_p2[k] != m_deb[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          m_deb[k] = m_p2[k];
          m_run[k] = 0;
          if (!m_deb[k]) m_press[k] = 1;
        end
      end else m_run[k] = 0;
      m_p2[k] = m_p1[k];
      m_p1[k] = raw[k];
    end
  endtask

  task automatic compare_all();
    check_val("fre_k",    fre_k,    m_fre);
    check_val("fre_upd",  fre_upd,  m_upd);
    check_val("step_idx", step_idx, m_step_idx);
    check_val("at_min",   at_min,   (m_fre == FMIN));
    check_val("at_max",   at_max,   (m_fre == FMAX));
    if (m_upd) $display("upd  t=%0t fre_k=%0d step_idx=%0d", $time, fre_k, step_idx);
  endtask

  // One clock: compare the state left by the last edge, then drive the next.
  task automatic cycle(input bit r, input bit u, input bit d, input bit s);
    if (m_valid) compare_all();
    rst = r; key_up_n = u; key_dn_n = d; key_step_n = s;
    model_edge(r, {s, d, u});
    if (r) m_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit u, input bit d, input bit s);
    for (int i = 0; i < n; i++) cycle(1'b0, u, d, s);
  endtask

  task automatic press_key(input int which, input int n_low, input int n_high);
    run(n_low,  which != 0, which != 1, which != 2);
    run(n_high, 1'b1, 1'b1, 1'b1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int seg [3];
    bit lvl [3];
    rst = 1'b1; key_up_n = 1'b1; key_dn_n = 1'b1; key_step_n = 1'b1;
    @(negedge clk);

    // 1: single up press, exact latency
    $display("scenario 1: single up press");
    cycle(1, 1, 1, 1);
    check_val("s1_reset_fre", fre_k, FINIT);
    check_val("s1_reset_step", step_idx, 0);
    run(7, 0, 1, 1);
    check_val("s1_before_edge", fre_k, FINIT);
    run(1, 0, 1, 1);
    check_val("s1_at_edge", fre_k, FINIT + 1);
    check_val("s1_pulse", fre_upd, 1);
    run(2, 0, 1, 1);
    run(20, 1, 1, 1);
    check_val("s1_final", fre_k, FINIT + 1);

    // 2: short glitches are rejected
    $display("scenario 2: glitches");
    cycle(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      run(3, 0, 1, 1);
      run(3, 1, 1, 1);
    end
    run(10, 1, 1, 1);
    check_val("s2_final", fre_k, FINIT);

    // 3: step 100, up held -> clamps at FRE_MAX
    $display("scenario 3: clamp at max");
    cycle(1, 1, 1, 1);
    press_key(2, 8, 8);
    press_key(2, 8, 8);
    check_val("s3_step", step_idx, 2);
    press_key(0, 50, 20);
    check_val("s3_fre", fre_k, FMAX);
    check_val("s3_at_max", at_max, 1);

    // 4: step 1000, down presses -> clamps at FRE_MIN
    $display("scenario 4: clamp at min");
    cycle(1, 1, 1, 1);
    for (int i = 0; i < 3; i++) press_key(2, 8, 8);
    check_val("s4_step", step_idx, 3);
    press_key(1, 8, 10);
    check_val("s4_fre", fre_k, FMIN);
    check_val("s4_at_min", at_min, 1);
    press_key(1, 8, 10);
    check_val("s4_fre2", fre_k, FMIN);

    // 5: up and down together cancel
    $display("scenario 5: both keys");
    cycle(1, 1, 1, 1);
    run(60, 0, 0, 1);
    run(10, 1, 1, 1);
    check_val("s5_fre", fre_k, FINIT);

    // 6: reset mid-repeat, key still held
    $display("scenario 6: reset mid-repeat");
    cycle(1, 1, 1, 1);
    run(270, 0, 1, 1);
    check_val("s6_before_rst", fre_k, 1050);
    cycle(1, 0, 1, 1);
    check_val("s6_rst_fre", fre_k, FINIT);
    check_val("s6_rst_step", step_idx, 0);
    run(7, 0, 1, 1);
    check_val("s6_hold_pre", fre_k, FINIT);
    run(5, 0, 1, 1);
    check_val("s6_hold_post", fre_k, FINIT + 1);
    run(10, 1, 1, 1);

    // Randomized key activity with occasional resets
    $display("random phase");
    for (int k = 0; k < 3; k++) begin
      seg[k] = 0; lvl[k] = 1'b1;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (seg[k] == 0) begin
          lvl[k] = ~lvl[k];
          if (!lvl[k] && k < 2 && $urandom_range(0, 5) == 0) seg[k] = $urandom_range(30, 90);
          else seg[k] = $urandom_range(1, 16);
        end
        seg[k]--;
      end
      cycle($urandom_range(0, 399) == 0, lvl[0], lvl[1], lvl[2]);
    end
    compare_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_freq_ctrl.md
Name: key_freq_ctrl

Overview:
Parametrised push-button frequency-word controller. It is the successor to the single-key incrementer and feeds the DDS phase-accumulator step for the AD9708 DAC path. It provides per-key debounce, up/down keys, a selectable decade step size, hold-to-repeat, and clamping of the frequency word to [FRE_MIN, FRE_MAX]. One clock domain; key inputs are raw, asynchronous and active-low.

Parameters:
FW, 32, width of frequency word.
FRE_INIT, 1000, fre_k value after reset.
FRE_MIN, 1, lower clamp; requires FRE_MIN <= FRE_INIT.
FRE_MAX, 2**31, upper clamp; requires FRE_INIT <= FRE_MAX < 2**FW.
STEP_BASE, 1, step at step_idx=0. Step at index i = STEP_BASE*10**i, i=0..3, precomputed as FW-bit constants.
DEB_CYCLES, 500000, consecutive stable synchronised samples required before the debounced state changes (>=2).
REPEAT_DELAY, 25000000, hold cycles after the press event before the first auto-repeat.
REPEAT_PERIOD, 5000000, cycles between auto-repeats while held.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
key_up_n  in  1  raw up key, 0=pressed
key_dn_n  in  1  raw down key, 0=pressed
key_step_n  in  1  raw step-select key, 0=pressed
fre_k  out  FW  current frequency word, registered
step_idx  out  2  current step decade index
fre_upd  out  1  one-cycle pulse in the same cycle fre_k takes a new value
at_min  out  1  fre_k == FRE_MIN, registered
at_max  out  1  fre_k == FRE_MAX, registered

Behaviour:
- Reset (rst=1 at a clk edge): fre_k=FRE_INIT, step_idx=0, fre_upd=0, at_min/at_max reflect FRE_INIT. Synchronisers are set to 1 (released). Debounce counters are cleared, debounced states are released, repeat FSMs go to IDLE. Reset applied mid-hold or mid-repeat aborts with no further updates. A key still held when reset is released must be seen as released-then-stable before it generates an event, so no event occurs at reset exit unless the input is stable low for the full DEB_CYCLES.
- Per key: a 2-FF synchroniser, then a debouncer. The debouncer counts consecutive cycles in which the synchronised sample differs from the debounced state. The counter clears on any cycle where they are equal. On reaching DEB_CYCLES the debounced state flips and the counter clears.
- Press event is a debounced 1->0 transition. Latency: a raw input held low from edge t gives a press event at edge t+2+DEB_CYCLES, and the fre_k update at the following edge.
- Repeat FSM (one for up, one for down):
  - IDLE: on a press event, issue a step request and go to WAIT with cnt=0.
  - WAIT: cnt++. At cnt==REPEAT_DELAY-1, issue a request, go to RPT, cnt=0.
  - RPT: cnt++. At cnt==REPEAT_PERIOD-1, issue a request, cnt=0.
  - WAIT/RPT: on debounced release, go to IDLE immediately with no request.
- Step key: press event only, no repeat. step_idx increments modulo 4 (3->0). The new step applies to requests from the next cycle on.
- Arithmetic uses FW+1 bits.
  - Up: nxt = fre_k+step; if nxt > FRE_MAX, nxt = FRE_MAX.
  - Down: if fre_k < FRE_MIN+step, nxt = FRE_MIN; else nxt = fre_k-step.
- Update rule: fre_k <= nxt one cycle after the request. fre_upd=1 only if nxt != fre_k, so a request at a clamp gives no pulse.
- Simultaneous up and down requests in the same cycle: both are dropped and fre_k is held. Both keys held: each FSM runs independently; coincident repeat requests cancel, non-coincident ones apply.
- at_min/at_max are updated in the same cycle as fre_k.

Test Plan:
(Parameters for all scenarios: FW=32, FRE_INIT=1000, FRE_MIN=10, FRE_MAX=1100, STEP_BASE=1, DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.)
1. Reset, then key_up_n low for 10 cycles and release -> fre_k 1000->1001 exactly 7 edges after the first low sample; one fre_upd pulse; no further change.
2. key_up_n glitching low for 3 cycles then high, repeated -> fre_k stays 1000 and fre_upd stays 0.
3. Step key pressed twice (step_idx=2, step 100), then key_up held 40 cycles after the press event -> fre_k 1100 on the first request, then held (clamped) with no fre_upd on repeats; at_max=1.
4. step_idx=3 (step 1000), fre_k=1000, one down press -> fre_k=10, at_min=1. A second press -> no change, no fre_upd.
5. key_up and key_dn pressed on the same cycle -> no change on the press event. Held -> repeat requests coincide and cancel; fre_k stays 1000.
6. rst asserted mid-RPT with fre_k=1050 and key held -> fre_k=1000, step_idx=0. No update until the key is released and re-pressed, or held 4+ cycles low after reset exit.
